// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op and sequencer state encodings for the ALU front-end
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_DIV = 2'b11
    } alu_op_e;

    // One-hot sequencer states, matching the ALU control-unit style
    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_LOAD0 = 6'b000010,
        S_LOAD1 = 6'b000100,
        S_LOAD2 = 6'b001000,
        S_WAIT  = 6'b010000,
        S_RESP  = 6'b100000
    } seq_state_e;

endpackage

// File: rtl/alu_watchdog.sv
// rtl/alu_watchdog.sv - WAIT-state cycle counter with clear, enable and terminal-count flag
module alu_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    assign tc = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Saturates at the terminal count; the sequencer leaves WAIT on tc anyway
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_bus_sequencer.sv
// rtl/alu_bus_sequencer.sv - command/response front-end replaying commands onto the serial ALU bus
module alu_bus_sequencer
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_x_hi,
    input  logic [7:0] cmd_x_lo,
    input  logic [7:0] cmd_y,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_hi,
    output logic [7:0] rsp_lo,
    output logic [1:0] rsp_op,
    output logic       rsp_timeout,
    output logic       busy,
    output logic       alu_begin,
    output logic [1:0] alu_op_code,
    output logic [7:0] alu_inbus,
    input  logic [7:0] alu_outbus,
    input  logic       alu_end,
    output logic       alu_abort
);

    seq_state_e state_q, state_d;
    alu_op_e    op_q;
    logic [7:0] x_lo_q, y_q;
    logic [7:0] h0, h1;
    logic       wd_tc;
    logic       accept;

    logic       cmd_ready_d, rsp_valid_d, rsp_timeout_d, busy_d;
    logic       alu_begin_d, alu_abort_d;
    logic [7:0] rsp_hi_d, rsp_lo_d, alu_inbus_d;
    logic [1:0] rsp_op_d, alu_op_code_d;

    alu_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk  (clk),
        .reset(reset),
        .clr  (state_q == S_LOAD2),
        .en   (state_q == S_WAIT),
        .tc   (wd_tc)
    );

    assign accept = (state_q == S_IDLE) && cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_LOAD0;
            S_LOAD0: state_d = S_LOAD1;
            S_LOAD1: state_d = S_LOAD2;
            S_LOAD2: state_d = S_WAIT;
            S_WAIT:  if (alu_end || wd_tc) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered
    always_comb begin
        cmd_ready_d   = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        alu_begin_d   = (state_d == S_LOAD0);
        rsp_valid_d   = (state_d == S_RESP);
        alu_abort_d   = (state_q == S_WAIT) && !alu_end && wd_tc;
        alu_op_code_d = 2'b00;
        alu_inbus_d   = 8'h00;
        rsp_hi_d      = rsp_hi;
        rsp_lo_d      = rsp_lo;
        rsp_op_d      = rsp_op;
        rsp_timeout_d = rsp_timeout;

        case (state_d)
            S_LOAD0: begin
                alu_op_code_d = cmd_op;
                alu_inbus_d   = cmd_x_hi;
            end
            S_LOAD1: begin
                alu_op_code_d = op_q;
                alu_inbus_d   = x_lo_q;
            end
            S_LOAD2: begin
                alu_op_code_d = op_q;
                alu_inbus_d   = y_q;
            end
            S_WAIT:  alu_op_code_d = op_q;
            default: ;
        endcase

        // The outbus value on the END cycle itself is deliberately not used
        if (state_q == S_WAIT && state_d == S_RESP) begin
            rsp_op_d = op_q;
            if (alu_end) begin
                rsp_hi_d      = h1;
                rsp_lo_d      = h0;
                rsp_timeout_d = 1'b0;
            end else begin
                rsp_hi_d      = 8'h00;
                rsp_lo_d      = 8'h00;
                rsp_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= ALU_ADD;
            x_lo_q      <= 8'h00;
            y_q         <= 8'h00;
            h0          <= 8'h00;
            h1          <= 8'h00;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_hi      <= 8'h00;
            rsp_lo      <= 8'h00;
            rsp_op      <= 2'b00;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            alu_begin   <= 1'b0;
            alu_op_code <= 2'b00;
            alu_inbus   <= 8'h00;
            alu_abort   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= alu_op_e'(cmd_op);
                x_lo_q <= cmd_x_lo;
                y_q    <= cmd_y;
            end
            if (state_q == S_WAIT) begin
                h1 <= h0;
                h0 <= alu_outbus;
            end
            cmd_ready   <= cmd_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_hi      <= rsp_hi_d;
            rsp_lo      <= rsp_lo_d;
            rsp_op      <= rsp_op_d;
            rsp_timeout <= rsp_timeout_d;
            busy        <= busy_d;
            alu_begin   <= alu_begin_d;
            alu_op_code <= alu_op_code_d;
            alu_inbus   <= alu_inbus_d;
            alu_abort   <= alu_abort_d;
        end
    end

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// tb/tb_alu_bus_sequencer.sv - directed scoreboard bench for alu_bus_sequencer
module tb_alu_bus_sequencer;

    logic       clk = 1'b0;
    logic       reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0] cmd_op, rsp_op, alu_op_code;
    logic [7:0] cmd_x_hi, cmd_x_lo, cmd_y, rsp_hi, rsp_lo, alu_inbus, alu_outbus;
    logic       rsp_timeout, busy, alu_begin, alu_end, alu_abort;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [1:0] op;
        logic       tmo;
    } rsp_t;

    rsp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   abort_cnt = 0;
    int   begin_cnt = 0;

    always #5 clk = ~clk;

    alu_bus_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x_hi   (cmd_x_hi),
        .cmd_x_lo   (cmd_x_lo),
        .cmd_y      (cmd_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_hi     (rsp_hi),
        .rsp_lo     (rsp_lo),
        .rsp_op     (rsp_op),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .alu_begin  (alu_begin),
        .alu_op_code(alu_op_code),
        .alu_inbus  (alu_inbus),
        .alu_outbus (alu_outbus),
        .alu_end    (alu_end),
        .alu_abort  (alu_abort)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (alu_abort) abort_cnt++;
        if (alu_begin) begin_cnt++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU results {A, Q}
    function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [7:0] xh,
                                            input logic [7:0] xl, input logic [7:0] y);
        logic [15:0] dvd;
        case (op)
            2'b00:   return {xh + y, xl};
            2'b01:   return {xh - y, xl};
            2'b10:   return {8'h00, xl} * {8'h00, y};
            default: begin
                dvd = {xh, xl};
                return {8'(dvd % {8'h00, y}), 8'(dvd / {8'h00, y})};
            end
        endcase
    endfunction

    // Drives a command and checks the three-word replay; ends in the first WAIT cycle
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] xh,
                            input logic [7:0] xl, input logic [7:0] y);
        int n = 0;
        cmd_op = op; cmd_x_hi = xh; cmd_x_lo = xl; cmd_y = y;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        if (!cmd_ready) chk("cmd_ready_wait", 16'(cmd_ready), 16'd1);
        begin_cnt = 0;
        tick();
        cmd_valid = 1'b0;
        cmd_x_hi = 8'hEE; cmd_x_lo = 8'hEE; cmd_y = 8'hEE;
        chk("load0_begin", 16'(alu_begin), 16'd1);
        chk("load0_inbus", 16'(alu_inbus), 16'(xh));
        chk("load0_opcode", 16'(alu_op_code), 16'(op));
        tick();
        chk("load1_inbus", 16'(alu_inbus), 16'(xl));
        tick();
        chk("load2_inbus", 16'(alu_inbus), 16'(y));
        chk("load2_cmd_ready", 16'(cmd_ready), 16'd0);
        tick();
        chk("wait_inbus", 16'(alu_inbus), 16'h00);
        chk("wait_opcode", 16'(alu_op_code), 16'(op));
        chk("begin_pulses", 16'(begin_cnt), 16'd1);
    endtask

    // lat junk cycles, then A, Q, END; with end_en=0 the ALU stays silent
    task automatic alu_model(input int lat, input logic [15:0] aq, input logic end_en);
        if (end_en) begin
            for (int i = 0; i < lat; i++) begin
                alu_outbus = 8'($urandom);
                tick();
            end
            alu_outbus = aq[15:8]; tick();
            alu_outbus = aq[7:0];  tick();
            alu_outbus = 8'hA5; alu_end = 1'b1; tick();
            alu_end = 1'b0; alu_outbus = 8'h00;
        end
    endtask

    task automatic get_rsp(input int hold, input int exp_wait);
        rsp_t e;
        int   n = 0;
        logic [7:0] hi0, lo0;
        while (!rsp_valid && n < 200) begin tick(); n++; end
        chk("rsp_valid_seen", 16'(rsp_valid), 16'd1);
        if (exp_wait >= 0) chk("timeout_wait_cycles", 16'(n), 16'(exp_wait));
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 16'd0, 16'd1);
            return;
        end
        e = sb.pop_front();
        chk("rsp_hi", 16'(rsp_hi), 16'(e.hi));
        chk("rsp_lo", 16'(rsp_lo), 16'(e.lo));
        chk("rsp_op", 16'(rsp_op), 16'(e.op));
        chk("rsp_timeout", 16'(rsp_timeout), 16'(e.tmo));
        chk("abort_at_resp", 16'(alu_abort), 16'(e.tmo));
        hi0 = rsp_hi; lo0 = rsp_lo;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 16'(rsp_valid), 16'd1);
            chk("hold_data", {rsp_hi, rsp_lo}, {hi0, lo0});
            chk("hold_cmd_ready", 16'(cmd_ready), 16'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_hs_valid", 16'(rsp_valid), 16'd0);
        chk("post_hs_cmd_ready", 16'(cmd_ready), 16'd1);
        chk("post_hs_busy", 16'(busy), 16'd0);
        chk("abort_pulses", 16'(abort_cnt), 16'(e.tmo));
    endtask

    task automatic do_op(input logic [1:0] op, input logic [7:0] xh, input logic [7:0] xl,
                         input logic [7:0] y, input int lat, input int hold);
        logic [15:0] aq;
        aq = alu_ref(op, xh, xl, y);
        sb.push_back('{hi: aq[15:8], lo: aq[7:0], op: op, tmo: 1'b0});
        abort_cnt = 0;
        send_cmd(op, xh, xl, y);
        alu_model(lat, aq, 1'b1);
        get_rsp(hold, -1);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b0;
        cmd_op = 2'b00; cmd_x_hi = 8'h12; cmd_x_lo = 8'h00; cmd_y = 8'h34;
        alu_outbus = 8'h00; alu_end = 1'b0;
        begin_cnt = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("reset_no_begin", 16'(begin_cnt), 16'd0);
        chk("reset_busy", 16'(busy), 16'd0);
        cmd_valid = 1'b0;
        reset = 1'b0;
        tick();
        chk("idle_cmd_ready", 16'(cmd_ready), 16'd1);
        chk("idle_busy", 16'(busy), 16'd0);
        chk("idle_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("idle_alu_outs", {4'h0, alu_begin, alu_abort, alu_op_code, alu_inbus}, 16'h0000);
        chk("idle_rsp_fields", {rsp_hi, rsp_lo}, 16'h0000);

        do_op(2'b00, 8'h12, 8'h00, 8'h34, 0, 0);
        do_op(2'b10, 8'h00, 8'h05, 8'h07, 12, 5);
        do_op(2'b11, 8'h00, 8'h64, 8'h07, 3, 1);
        do_op(2'b01, 8'h50, 8'h9C, 8'h21, 1, 0);

        // Watchdog abort: END never arrives
        sb.push_back('{hi: 8'h00, lo: 8'h00, op: 2'b10, tmo: 1'b1});
        abort_cnt = 0;
        alu_outbus = 8'h77;
        send_cmd(2'b10, 8'h00, 8'h09, 8'h09);
        get_rsp(2, 64);
        alu_outbus = 8'h00;
        do_op(2'b00, 8'h01, 8'h02, 8'h03, 2, 0);

        // END on the terminal-count cycle wins over the abort
        do_op(2'b11, 8'h01, 8'h00, 8'h10, 61, 1);

        // Stray END in IDLE is ignored
        alu_end = 1'b1;
        tick(); tick();
        alu_end = 1'b0;
        chk("stray_end_busy", 16'(busy), 16'd0);
        chk("stray_end_valid", 16'(rsp_valid), 16'd0);
        chk("stray_end_ready", 16'(cmd_ready), 16'd1);

        // Reset during WAIT
        abort_cnt = 0;
        send_cmd(2'b10, 8'h00, 8'h03, 8'h04);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_valid", 16'(rsp_valid), 16'd0);
        chk("midreset_busy", 16'(busy), 16'd0);
        chk("midreset_ready", 16'(cmd_ready), 16'd1);
        chk("midreset_opcode", 16'(alu_op_code), 16'd0);
        chk("midreset_no_abort", 16'(abort_cnt), 16'd0);
        do_op(2'b01, 8'h10, 8'h00, 8'h20, 0, 0);

        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_bus_sequencer.md
Name: alu_bus_sequencer

Overview:
Upstream front-end for the 8-bit sequential ALU. It accepts one full command per valid/ready handshake, replays it onto the ALU's serial interface as a BEGIN pulse plus three consecutive inbus words, and watches outbus and END. It then returns the 16-bit result (A:Q) on a valid/ready response port. A watchdog aborts the ALU if END never arrives.

Parameters:
TIMEOUT_CYCLES, 64, max WAIT-state cycles before abort; must be >= 4
CNT_W, 7, watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command
cmd_op  in  2  00 add, 01 sub, 10 mul (radix-4), 11 div (SRT-2)
cmd_x_hi  in  8  first operand word, loaded into ALU A (dividend high for div; ignored by ALU for mul)
cmd_x_lo  in  8  second operand word, loaded into ALU Q
cmd_y  in  8  third operand word, loaded into ALU M
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_hi  out  8  ALU A result (sum/diff, product high, remainder)
rsp_lo  out  8  ALU Q result (product low, quotient)
rsp_op  out  2  op of the command that produced this response
rsp_timeout  out  1  response is a watchdog abort; rsp_hi/rsp_lo = 0x00
busy  out  1  high in any state other than IDLE
alu_begin  out  1  to ALU BEGIN
alu_op_code  out  2  to ALU op_code
alu_inbus  out  8  to ALU inbus
alu_outbus  in  8  from ALU outbus
alu_end  in  1  from ALU END
alu_abort  out  1  one-cycle pulse, ORed by top level into the ALU reset

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_hi=rsp_lo=0x00, rsp_op=00, rsp_timeout=0, busy=0, alu_begin=0, alu_op_code=00, alu_inbus=0x00, alu_abort=0. State=IDLE, watchdog=0, history registers=0.
- FSM states: IDLE, LOAD0, LOAD1, LOAD2, WAIT, RESP. All outputs are registered.
- IDLE: cmd_ready=1. When cmd_valid & cmd_ready, register op/x_hi/x_lo/y and go to LOAD0.
- LOAD0: alu_begin=1, alu_inbus=x_hi. Then LOAD1.
- LOAD1: alu_begin=0, alu_inbus=x_lo. Then LOAD2.
- LOAD2: alu_inbus=y. Then WAIT, clearing the watchdog.
- alu_op_code = registered op from LOAD0 through WAIT. It is 00 in IDLE and RESP.
- alu_inbus = 0x00 outside LOAD0..LOAD2.
- WAIT: each cycle, shift alu_outbus into a 2-deep history: h1<=h0, h0<=alu_outbus. The watchdog increments every cycle.
- On alu_end=1 in WAIT: rsp_hi=h1 (A pushed first), rsp_lo=h0 (Q pushed second), rsp_timeout=0, go to RESP. The outbus value on the END cycle itself is not used.
- ALU protocol contract: the ALU drives A then Q on outbus in the two cycles immediately preceding END.
- Watchdog: if the count reaches TIMEOUT_CYCLES-1 with no alu_end, pulse alu_abort for 1 cycle and go to RESP with rsp_timeout=1 and result 0x0000. If alu_end and the timeout coincide, alu_end wins (normal response, no abort).
- RESP: rsp_valid=1, and response fields are stable until rsp_valid & rsp_ready. On that handshake, return to IDLE and set cmd_ready=1 in the next cycle. Responses never overlap commands; there is one outstanding command at most.
- Back-to-back operation: the earliest next alu_begin is 2 cycles after rsp handshake (IDLE accept, then LOAD0).
- alu_end outside WAIT is ignored.
- cmd_valid is ignored unless in IDLE.
- Reset mid-operation: reset forces all state to reset values in the same clock edge. alu_abort is not pulsed, because the shared reset clears the ALU.

Decomposition:
- Shared package alu_pkg:
  - op encodings ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_MUL=2'b10, ALU_DIV=2'b11.
  - sequencer state encoding (one-hot, 6 bits, matching the control-unit style).
- One sub-module is natural: alu_watchdog (counter with clear, enable and terminal-count flag, parameterised by TIMEOUT_CYCLES/CNT_W).
- History shift and FSM stay in the top module.

Test Plan:
- Reset then idle: cmd_ready=1, busy=0, all alu_* outputs 0. Apply a cmd with reset held high -> no alu_begin pulse is ever issued.
- Add command: op=00, x_hi=0x12, x_lo=0x00, y=0x34, using an ALU model that drives A=0x46, Q=0x00 then END. Required: alu_begin for exactly 1 cycle; inbus sequence 0x12, 0x00, 0x34; rsp_hi=0x46, rsp_lo=0x00, rsp_op=00, rsp_timeout=0.
- Mul command: op=10, x_lo=0x05, y=0x07, ALU model responds after 12 cycles. Required: rsp_hi=0x00, rsp_lo=0x23, rsp_op=10. Hold rsp_ready=0 for 5 cycles and check that rsp fields stay stable and cmd_ready=0.
- Div command: op=11, x_hi=0x00, x_lo=0x64, y=0x07. Required: rsp_hi=0x02 (remainder), rsp_lo=0x0E (quotient).
- Timeout: ALU model never asserts END, TIMEOUT_CYCLES=64. Required: alu_abort high for exactly 1 cycle at WAIT cycle 64; rsp_timeout=1, rsp=0x0000. The next command proceeds normally.
- Edge cases:
  - alu_end coinciding with the terminal count gives a normal response with no abort.
  - reset asserted during WAIT returns to IDLE next cycle with rsp_valid=0.
  - a stray alu_end pulse in IDLE is ignored.
